// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer for a 16x32 single-port
// data memory with a registered read port.
//
// Requester A is the core load/store stage, requester B the loader/debug port.
// A granted command occupies the memory for one ACCESS cycle. The result is
// returned in the following RESP cycle. A new arbitration may be made in that
// same RESP cycle, so sustained throughput is one access every two cycles.
//
// Ports:
//   CLOCK_50              system clock, rising edge
//   RESET                 synchronous reset, active-high
//   a_req/a_we/a_addr/a_wdata   requester A command (held until a_gnt)
//   a_gnt                 one-cycle pulse in ACCESS: A command accepted
//   a_done                one-cycle pulse in RESP: A access complete
//   a_rdata               A read data (written word for writes)
//   b_*                   same as a_*, for requester B
//   mem_addr/mem_wdata/mem_we   command to the memory
//   mem_rdata             registered read data from the memory
//   busy                  high in ACCESS and RESP
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_b_q;   // 1: B won the most recent grant
    logic              win_b_q;    // 1: the access in flight belongs to B
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              a_gnt_q;
    logic              b_gnt_q;
    logic              a_done_q;
    logic              b_done_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic              arb_en_d;
    logic              pick_b_d;

    // Arbitration decision: who would win if an arbitration happens now.
    always_comb begin
        arb_en_d = 1'b0;
        pick_b_d = 1'b0;
        if ((state_q == S_IDLE) || (state_q == S_RESP)) begin
            arb_en_d = a_req | b_req;
        end else begin
            arb_en_d = 1'b0;
        end
        if (a_req && b_req) begin
            // Round robin favours whoever did not win last; fixed priority favours A.
            pick_b_d = RR_EN ? ~last_b_q : 1'b0;
        end else begin
            pick_b_d = b_req;
        end
    end

    // Sequencer FSM with registered memory command, grant and done pulses.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            last_b_q    <= 1'b1;
            win_b_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
            mem_we_q <= 1'b0;

            // Keep the returned word so rdata holds until the requester's next done.
            if (state_q == S_RESP) begin
                if (win_b_q) begin
                    b_rdata_q <= mem_rdata;
                end else begin
                    a_rdata_q <= mem_rdata;
                end
            end

            case (state_q)
                S_IDLE, S_RESP: begin
                    if (arb_en_d) begin
                        mem_addr_q  <= pick_b_d ? b_addr  : a_addr;
                        mem_wdata_q <= pick_b_d ? b_wdata : a_wdata;
                        mem_we_q    <= pick_b_d ? b_we    : a_we;
                        a_gnt_q     <= ~pick_b_d;
                        b_gnt_q     <= pick_b_d;
                        win_b_q     <= pick_b_d;
                        last_b_q    <= pick_b_d;
                        state_q     <= S_ACCESS;
                    end else begin
                        state_q     <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    a_done_q <= ~win_b_q;
                    b_done_q <= win_b_q;
                    state_q  <= S_RESP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The memory's read data only arrives in the RESP cycle itself, so the
    // done cycle forwards it directly; afterwards the captured copy is shown.
    // Done is masked by RESET so that a reset during RESP completes nothing.
    assign a_done    = a_done_q & ~RESET;
    assign b_done    = b_done_q & ~RESET;
    assign a_rdata   = a_done ? mem_rdata : a_rdata_q;
    assign b_rdata   = b_done ? mem_rdata : b_rdata_q;
    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    // Round-robin instance
    logic        a_gnt, a_done, b_gnt, b_done, mem_we, busy;
    logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic [3:0]  mem_addr;
    logic [31:0] mem [16];

    // Fixed-priority instance
    logic        fa_gnt, fa_done, fb_gnt, fb_done, fmem_we, fbusy;
    logic [31:0] fa_rdata, fb_rdata, fmem_wdata, fmem_rdata;
    logic [3:0]  fmem_addr;
    logic [31:0] fmem [16];

    int n_pass = 0;
    int n_total = 0;

    always #10 clk = ~clk;

    dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .RR_EN(1'b1)) dut (
        .CLOCK_50(clk), .RESET(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(4), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
        .CLOCK_50(clk), .RESET(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(fa_gnt), .a_done(fa_done), .a_rdata(fa_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(fb_gnt), .b_done(fb_done), .b_rdata(fb_rdata),
        .mem_addr(fmem_addr), .mem_wdata(fmem_wdata), .mem_we(fmem_we),
        .mem_rdata(fmem_rdata), .busy(fbusy)
    );

    // Single-port memories with registered read, write-then-read on a write.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
        if (fmem_we) fmem[fmem_addr] <= fmem_wdata;
        fmem_rdata <= fmem_we ? fmem_wdata : fmem[fmem_addr];
    end

    typedef struct {
        logic        rst;
        logic        areq, awe;
        logic [3:0]  aaddr;
        logic [31:0] awd;
        logic        breq, bwe;
        logic [3:0]  baddr;
        logic [31:0] bwd;
        logic        agnt, adone;
        logic [31:0] ard;
        logic        bgnt, bdone;
        logic [31:0] brd;
        logic        mwe;
        logic [3:0]  maddr;
        logic        busy;
    } vec_t;

    localparam int NV = 39;
    vec_t vecs [NV];

    task automatic sv(input int i, input logic r,
                      input logic aq, input logic aw, input logic [3:0] aa, input logic [31:0] ad,
                      input logic bq, input logic bw, input logic [3:0] ba, input logic [31:0] bd,
                      input logic ag, input logic adn, input logic [31:0] ar,
                      input logic bg, input logic bdn, input logic [31:0] br,
                      input logic mw, input logic [3:0] ma, input logic bz);
        vecs[i] = '{r, aq, aw, aa, ad, bq, bw, ba, bd, ag, adn, ar, bg, bdn, br, mw, ma, bz};
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    initial begin
        // Each row: inputs driven this cycle, outputs expected this cycle (RR instance).
        //       i  rst areq awe aaddr awdata         breq bwe baddr bwdata        agnt adone ardata        bgnt bdone brdata        mwe maddr busy
        sv( 0, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,4'd0,1'b0);
        sv( 1, 1'b0, 1'b1,1'b1,4'd3,32'hDEADBEEF,   1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,4'd0,1'b0);
        sv( 2, 1'b0, 1'b1,1'b1,4'd3,32'hDEADBEEF,   1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b1,4'd3,1'b1);
        sv( 3, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b1,32'hDEADBEEF,  1'b0,1'b0,32'h0,         1'b0,4'd3,1'b1);
        sv( 4, 1'b0, 1'b1,1'b0,4'd3,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'hDEADBEEF,  1'b0,1'b0,32'h0,         1'b0,4'd3,1'b0);
        sv( 5, 1'b0, 1'b1,1'b0,4'd3,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,32'hDEADBEEF,  1'b0,1'b0,32'h0,         1'b0,4'd3,1'b1);
        sv( 6, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b1,32'hDEADBEEF,  1'b0,1'b0,32'h0,         1'b0,4'd3,1'b1);
        sv( 7, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'hDEADBEEF,  1'b0,1'b0,32'h0,         1'b0,4'd3,1'b0);
        // contention after A won last: B first, then alternating
        sv( 8, 1'b0, 1'b1,1'b1,4'd5,32'hA5A50001,   1'b1,1'b0,4'd3,32'h0,          1'b0,1'b0,32'hDEADBEEF,  1'b0,1'b0,32'h0,         1'b0,4'd3,1'b0);
        sv( 9, 1'b0, 1'b1,1'b1,4'd5,32'hA5A50001,   1'b1,1'b0,4'd3,32'h0,          1'b0,1'b0,32'hDEADBEEF,  1'b1,1'b0,32'h0,         1'b0,4'd3,1'b1);
        sv(10, 1'b0, 1'b1,1'b1,4'd5,32'hA5A50001,   1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'hDEADBEEF,  1'b0,1'b1,32'hDEADBEEF,  1'b0,4'd3,1'b1);
        sv(11, 1'b0, 1'b1,1'b1,4'd5,32'hA5A50001,   1'b1,1'b0,4'd5,32'h0,          1'b1,1'b0,32'hDEADBEEF,  1'b0,1'b0,32'hDEADBEEF,  1'b1,4'd5,1'b1);
        sv(12, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd5,32'h0,          1'b0,1'b1,32'hA5A50001,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd5,1'b1);
        sv(13, 1'b0, 1'b1,1'b1,4'd6,32'hA5A50002,   1'b1,1'b0,4'd5,32'h0,          1'b0,1'b0,32'hA5A50001,  1'b1,1'b0,32'hDEADBEEF,  1'b0,4'd5,1'b1);
        sv(14, 1'b0, 1'b1,1'b1,4'd6,32'hA5A50002,   1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'hA5A50001,  1'b0,1'b1,32'hA5A50001,  1'b0,4'd5,1'b1);
        sv(15, 1'b0, 1'b1,1'b1,4'd6,32'hA5A50002,   1'b1,1'b0,4'd6,32'h0,          1'b1,1'b0,32'hA5A50001,  1'b0,1'b0,32'hA5A50001,  1'b1,4'd6,1'b1);
        sv(16, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd6,32'h0,          1'b0,1'b1,32'hA5A50002,  1'b0,1'b0,32'hA5A50001,  1'b0,4'd6,1'b1);
        sv(17, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd6,32'h0,          1'b0,1'b0,32'hA5A50002,  1'b1,1'b0,32'hA5A50001,  1'b0,4'd6,1'b1);
        sv(18, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'hA5A50002,  1'b0,1'b1,32'hA5A50002,  1'b0,4'd6,1'b1);
        sv(19, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'hA5A50002,  1'b0,1'b0,32'hA5A50002,  1'b0,4'd6,1'b0);
        // reset during ACCESS of a B write: write lands, no done
        sv(20, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b1,4'd7,32'h12345678,   1'b0,1'b0,32'hA5A50002,  1'b0,1'b0,32'hA5A50002,  1'b0,4'd6,1'b0);
        sv(21, 1'b1, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b1,4'd7,32'h12345678,   1'b0,1'b0,32'hA5A50002,  1'b1,1'b0,32'hA5A50002,  1'b1,4'd7,1'b1);
        sv(22, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,4'd0,1'b0);
        // first contention after reset: A wins
        sv(23, 1'b0, 1'b1,1'b0,4'd7,32'h0,          1'b1,1'b0,4'd3,32'h0,          1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,4'd0,1'b0);
        sv(24, 1'b0, 1'b1,1'b0,4'd7,32'h0,          1'b1,1'b0,4'd3,32'h0,          1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,4'd7,1'b1);
        sv(25, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd3,32'h0,          1'b0,1'b1,32'h12345678,  1'b0,1'b0,32'h0,         1'b0,4'd7,1'b1);
        sv(26, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd3,32'h0,          1'b0,1'b0,32'h12345678,  1'b1,1'b0,32'h0,         1'b0,4'd3,1'b1);
        sv(27, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b0,1'b1,32'hDEADBEEF,  1'b0,4'd3,1'b1);
        sv(28, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd3,1'b0);
        // back-to-back A: write then a new request in the RESP cycle
        sv(29, 1'b0, 1'b1,1'b1,4'd0,32'h1,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd3,1'b0);
        sv(30, 1'b0, 1'b1,1'b1,4'd0,32'h1,          1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b1,4'd0,1'b1);
        sv(31, 1'b0, 1'b1,1'b0,4'd7,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b1,32'h1,         1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd0,1'b1);
        sv(32, 1'b0, 1'b1,1'b0,4'd7,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,32'h1,         1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd7,1'b1);
        sv(33, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b1,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd7,1'b1);
        sv(34, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd7,1'b0);
        // reset during RESP: done suppressed
        sv(35, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd7,1'b0);
        sv(36, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b1,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b1,1'b0,32'hDEADBEEF,  1'b0,4'd0,1'b1);
        sv(37, 1'b1, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h12345678,  1'b0,1'b0,32'hDEADBEEF,  1'b0,4'd0,1'b1);
        sv(38, 1'b0, 1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,4'd0,32'h0,          1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,         1'b0,4'd0,1'b0);

        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst     = vecs[i].rst;
            a_req   = vecs[i].areq;  a_we = vecs[i].awe;  a_addr = vecs[i].aaddr;  a_wdata = vecs[i].awd;
            b_req   = vecs[i].breq;  b_we = vecs[i].bwe;  b_addr = vecs[i].baddr;  b_wdata = vecs[i].bwd;
            #1;
            chk("a_gnt",    i, 32'(a_gnt),    32'(vecs[i].agnt));
            chk("a_done",   i, 32'(a_done),   32'(vecs[i].adone));
            chk("a_rdata",  i, a_rdata,       vecs[i].ard);
            chk("b_gnt",    i, 32'(b_gnt),    32'(vecs[i].bgnt));
            chk("b_done",   i, 32'(b_done),   32'(vecs[i].bdone));
            chk("b_rdata",  i, b_rdata,       vecs[i].brd);
            chk("mem_we",   i, 32'(mem_we),   32'(vecs[i].mwe));
            chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].maddr));
            chk("busy",     i, 32'(busy),     32'(vecs[i].busy));
            @(posedge clk);
            #1;
        end

        // Fixed priority: A re-requests continuously; B only wins once A drops.
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int c = 0; c < 11; c++) begin
            if (c == 8) a_req = 1'b0;
            if (c == 10) b_req = 1'b0;
            #1;
            chk("fp_a_gnt",  100 + c, 32'(fa_gnt),  32'((c % 2 == 1) && (c < 9)));
            chk("fp_b_gnt",  100 + c, 32'(fb_gnt),  32'(c == 9));
            chk("fp_b_done", 100 + c, 32'(fb_done), 32'(c == 10));
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16x32 single-port data memory.
- Requester A is the core datapath (load/store stage). Requester B is the loader/debug port.
- Serialises accesses onto the memory's address, write-data and write-enable inputs, and captures the memory's registered read data.
- Returns read data to the winning requester with a done pulse.

Parameters:
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 32, memory word width
- RR_EN, 1, 1 = round-robin on contention; 0 = fixed priority, A wins

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous reset, active-high
- a_req  in  1  A access request; held with a_we/a_addr/a_wdata stable until a_gnt
- a_we  in  1  A write (1) / read (0)
- a_addr  in  ADDR_W  A word address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  one-cycle pulse: A command accepted
- a_done  out  1  one-cycle pulse: A access complete, a_rdata valid
- a_rdata  out  DATA_W  A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as A, for requester B
- mem_addr  out  ADDR_W  to memory address input
- mem_wdata  out  DATA_W  to memory write-data input
- mem_we  out  1  to memory write-enable input
- mem_rdata  in  DATA_W  from memory registered read-data output
- busy  out  1  high in ACCESS and RESP states

Behaviour:
- Memory model: samples address/we/wdata on rising edge E; read data appears on mem_rdata after E.
  - Write-then-read semantics: a write returns the newly written word.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration is performed in IDLE or RESP when any req is high:
  - Winner's we/addr/wdata are registered onto mem_* outputs.
  - Winner's gnt is registered high.
  - Next state is ACCESS.
  - Otherwise: IDLE stays IDLE; RESP goes to IDLE.
- ACCESS (exactly 1 cycle):
  - mem_* are driven with the command; mem_we is high only here and only for writes.
  - gnt of the winner is high in this cycle only.
  - Next state is RESP.
- RESP (1 cycle):
  - done of the winner is high.
  - *_rdata is loaded from mem_rdata and holds until that requester's next done.
  - For writes, rdata equals the written word.
  - A new arbitration may be made in this same cycle.
  - Requesters must have dropped or changed req by RESP (they see gnt in ACCESS).
- Latency: req high in cycle N (state IDLE) -> gnt in N+1, done + rdata in N+2.
- Sustained throughput: one access per 2 cycles.
- Round robin (RR_EN=1):
  - A last_winner register records the winner at every grant.
  - On simultaneous a_req and b_req, the requester that is not last_winner wins.
  - A lone request always wins.
- Fixed priority (RR_EN=0): A wins all contention; last_winner is still updated but unused.
- Outputs outside their active cycle: mem_we=0 outside ACCESS; gnt/done=0 except as above; mem_addr/mem_wdata hold their last values.
- Reset values:
  - state=IDLE, last_winner=B (so A wins the first contention)
  - mem_addr=0, mem_wdata=0, mem_we=0
  - a_gnt=b_gnt=a_done=b_done=0, a_rdata=b_rdata=0, busy=0
- Reset mid-operation:
  - RESET high in ACCESS: the memory still samples that edge, so a write is committed (memory has no reset), but no done is issued.
  - RESET high in RESP: done is suppressed.
  - All state returns to reset values the next cycle.
- req deasserted before gnt (protocol violation): the command already registered still executes and done still fires. The bench flags this as an error; the RTL does not.
- Address/data are passed unmodified; no width conversion or bounds check (ADDR_W covers all words).

Test Plan:
- Reset, then A write: a_req=1, a_we=1, a_addr=3, a_wdata=0xDEADBEEF -> a_gnt in cycle+1 with mem_we=1, mem_addr=3; a_done in cycle+2 with a_rdata=0xDEADBEEF; mem_we=0 afterwards.
- A read of address 3 after the write -> a_done 2 cycles after req, a_rdata=0xDEADBEEF; mem_we never high.
- Contention, RR_EN=1: a_req and b_req both held continuously, each dropping req for one cycle after its gnt -> grants alternate A,B,A,B; done pulses every 2 cycles; B reads return values A wrote.
- RR_EN=0, both requesting, A re-requests immediately after each grant -> B never granted while A requests; B granted the first arbitration cycle A is idle.
- Reset during ACCESS of B write (addr 7, 0x12345678) -> no b_done; after reset, A read of addr 7 returns 0x12345678; all outputs at reset values the cycle after RESET.
- Back-to-back A accesses: write addr 0 = 0x1, then a new req presented in the RESP cycle -> second gnt in the cycle after RESP; no idle cycle; busy stays high across both accesses.
